// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// slave  : arbiter view (takes cache requests and memory responses).
// master : environment view (caches and memory model).
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  // I-cache side
  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDR;
  logic [DATA_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;
  // D-cache side
  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDR;
  logic [DATA_W-1:0] D_WRITEDATA;
  logic [DATA_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;
  // Memory side
  logic              M_READ;
  logic              M_WRITE;
  logic [ADDR_W-1:0] M_ADDR;
  logic [DATA_W-1:0] M_WRITEDATA;
  logic [DATA_W-1:0] M_READDATA;
  logic              M_BUSYWAIT;
  // Debug
  logic [1:0]        OWNER;

  modport slave (
    input  I_READ, I_ADDR,
    output I_READDATA, I_BUSYWAIT,
    input  D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
    output D_READDATA, D_BUSYWAIT,
    output M_READ, M_WRITE, M_ADDR, M_WRITEDATA,
    input  M_READDATA, M_BUSYWAIT,
    output OWNER
  );

  modport master (
    output I_READ, I_ADDR,
    input  I_READDATA, I_BUSYWAIT,
    output D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
    input  D_READDATA, D_BUSYWAIT,
    input  M_READ, M_WRITE, M_ADDR, M_WRITEDATA,
    output M_READDATA, M_BUSYWAIT,
    input  OWNER
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Main-memory port arbiter for I-cache and D-cache.
// D-cache has priority; a saturating starvation counter forces an I grant after
// STARVE_LIMIT consecutive D grants taken while I_READ was pending.
// One memory transaction at a time: IDLE -> GRANT_x -> RELEASE -> IDLE.
module mem_bus_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input logic               CLK,
  input logic               RESET_N,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10,
    RELEASE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q,   state_d;
  owner_t            owner_q,   owner_d;
  logic              m_read_q,  m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q,  m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [3:0]        starve_q,  starve_d;
  logic              first_q,   first_d;

  logic d_req;
  logic grant_i;
  logic grant_d;

  // Arbitration decision and next-state / next-output computation
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    starve_d  = starve_q;
    first_d   = first_q;

    d_req   = bus.D_READ | bus.D_WRITE;
    // I wins when starved, or when D is not asking at all
    grant_i = bus.I_READ & ((starve_q == LIMIT) | ~d_req);
    grant_d = d_req & ~grant_i;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d   = GRANT_I;
          owner_d   = OWN_I;
          m_read_d  = 1'b1;
          m_write_d = 1'b0;
          m_addr_d  = bus.I_ADDR;
          m_wdata_d = '0;
          starve_d  = '0;
          first_d   = 1'b1;
        end else if (grant_d) begin
          state_d   = GRANT_D;
          owner_d   = OWN_D;
          // simultaneous read and write-back: the write-back is performed
          m_write_d = bus.D_WRITE;
          m_read_d  = ~bus.D_WRITE;
          m_addr_d  = bus.D_ADDR;
          m_wdata_d = bus.D_WRITEDATA;
          if (bus.I_READ) begin
            starve_d = (starve_q < LIMIT) ? starve_q + 4'd1 : starve_q;
          end else begin
            starve_d = '0;
          end
          first_d   = 1'b1;
        end
      end
      GRANT_I, GRANT_D: begin
        // the edge right after the grant never completes: 2-cycle minimum
        if (first_q) begin
          first_d = 1'b0;
        end else if (!bus.M_BUSYWAIT) begin
          if (m_read_q) begin
            if (state_q == GRANT_I) i_rdata_d = bus.M_READDATA;
            else                    d_rdata_d = bus.M_READDATA;
          end
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      starve_q  <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      starve_q  <= starve_d;
      first_q   <= first_d;
    end
  end

  assign bus.M_READ      = m_read_q;
  assign bus.M_WRITE     = m_write_q;
  assign bus.M_ADDR      = m_addr_q;
  assign bus.M_WRITEDATA = m_wdata_q;
  assign bus.I_READDATA  = i_rdata_q;
  assign bus.D_READDATA  = d_rdata_q;
  assign bus.OWNER       = owner_q;

  // Stall is the request level, lifted only in the owner's RELEASE cycle
  assign bus.I_BUSYWAIT = bus.I_READ &
                          ~((state_q == RELEASE) & (owner_q == OWN_I));
  assign bus.D_BUSYWAIT = (bus.D_READ | bus.D_WRITE) &
                          ~((state_q == RELEASE) & (owner_q == OWN_D));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected transactions,
// a negedge monitor pops them at each memory grant and checks release data.
module tb_mem_bus_arbiter;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  mem_bus_arbiter_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  mem_bus_arbiter #(
    .ADDR_W(6),
    .DATA_W(32),
    .STARVE_LIMIT(3)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0]  owner;
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int unsigned dur;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned passes = 0;

  // Memory model: fixed per-test latency, read data from a table
  logic [31:0] mem [64];
  int unsigned mem_lat = 2;
  int unsigned mem_cnt = 0;
  assign bus.M_READDATA = mem[bus.M_ADDR];

  always @(negedge CLK) begin
    if (bus.M_READ || bus.M_WRITE) begin
      mem_cnt        <= mem_cnt + 1;
      bus.M_BUSYWAIT <= (mem_cnt + 1 < mem_lat);
    end else begin
      mem_cnt        <= 0;
      bus.M_BUSYWAIT <= (mem_lat != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic [1:0] o, input logic w, input logic [5:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int unsigned dur);
    exp_t e;
    e.owner = o; e.wr = w; e.addr = a; e.wdata = wd; e.rd = rd; e.dur = dur;
    sb.push_back(e);
  endtask

  // Monitor: grant fields, grant length, release data/owner, OWNER back to 00
  initial begin
    logic prev_s, in_txn, after_rel, s, i_rel, d_rel;
    int unsigned dur;
    exp_t cur;
    prev_s = 0; in_txn = 0; after_rel = 0; dur = 0;
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        prev_s = 0; in_txn = 0; after_rel = 0; dur = 0;
      end else begin
        s = bus.M_READ | bus.M_WRITE;
        if (after_rel) begin
          chk("owner_idle", 32'(bus.OWNER), 32'd0);
          after_rel = 0;
        end
        if (s && !prev_s) begin
          if (sb.size() == 0) begin
            chk("grant_expected", 32'(sb.size()), 32'd1);
          end else begin
            cur = sb.pop_front();
            chk("grant_owner", 32'(bus.OWNER), 32'(cur.owner));
            chk("grant_m_write", 32'(bus.M_WRITE), 32'(cur.wr));
            chk("grant_m_read", 32'(bus.M_READ), 32'(!cur.wr));
            chk("grant_m_addr", 32'(bus.M_ADDR), 32'(cur.addr));
            if (cur.wr) chk("grant_m_wdata", bus.M_WRITEDATA, cur.wdata);
            in_txn = 1;
            dur = 0;
          end
        end
        if (s) dur++;
        if (!s && prev_s && in_txn) chk("grant_cycles", dur, cur.dur);
        i_rel = bus.I_READ && !bus.I_BUSYWAIT;
        d_rel = (bus.D_READ || bus.D_WRITE) && !bus.D_BUSYWAIT;
        if (i_rel || d_rel) begin
          if (!in_txn) begin
            chk("release_in_txn", 32'(in_txn), 32'd1);
          end else begin
            chk("release_owner", 32'(bus.OWNER), 32'(cur.owner));
            chk("release_client", 32'({d_rel, i_rel}), 32'(cur.owner));
            chk("release_rdata",
                (cur.owner == 2'b01) ? bus.I_READDATA : bus.D_READDATA, cur.rd);
            in_txn = 0;
            after_rel = 1;
          end
        end
        prev_s = s;
      end
    end
  end

  // Clients assert at a negedge, wait for their BUSYWAIT low, drop after the next edge
  task automatic i_req(input logic [5:0] a);
    logic got;
    got = 0;
    @(negedge CLK);
    bus.I_READ = 1'b1;
    bus.I_ADDR = a;
    for (int unsigned n = 0; n < 300 && !got; n++) begin
      @(negedge CLK);
      if (!bus.I_BUSYWAIT) got = 1;
    end
    if (!got) chk("i_wait_timeout", 32'(got), 32'd1);
    @(posedge CLK);
    #1 bus.I_READ = 1'b0;
  endtask

  task automatic d_req(input logic w, input logic r, input logic [5:0] a, input logic [31:0] wd);
    logic got;
    got = 0;
    @(negedge CLK);
    bus.D_WRITE = w;
    bus.D_READ = r;
    bus.D_ADDR = a;
    bus.D_WRITEDATA = wd;
    for (int unsigned n = 0; n < 300 && !got; n++) begin
      @(negedge CLK);
      if (!bus.D_BUSYWAIT) got = 1;
    end
    if (!got) chk("d_wait_timeout", 32'(got), 32'd1);
    @(posedge CLK);
    #1;
    bus.D_WRITE = 1'b0;
    bus.D_READ = 1'b0;
  endtask

  initial begin
    logic [31:0] d_rd_last;
    logic got;
    for (int unsigned i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[5] = 32'hDEADBEEF;
    bus.I_READ = 0; bus.I_ADDR = '0;
    bus.D_READ = 0; bus.D_WRITE = 0; bus.D_ADDR = '0; bus.D_WRITEDATA = '0;
    d_rd_last = '0;

    // Reset values, BUSYWAIT follows request during reset
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_m_read", 32'(bus.M_READ), 32'd0);
    chk("rst_m_write", 32'(bus.M_WRITE), 32'd0);
    chk("rst_m_addr", 32'(bus.M_ADDR), 32'd0);
    chk("rst_m_wdata", bus.M_WRITEDATA, 32'd0);
    chk("rst_owner", 32'(bus.OWNER), 32'd0);
    chk("rst_i_rdata", bus.I_READDATA, 32'd0);
    chk("rst_d_rdata", bus.D_READDATA, 32'd0);
    bus.I_READ = 1'b1;
    #1 chk("rst_i_busy_hi", 32'(bus.I_BUSYWAIT), 32'd1);
    bus.I_READ = 1'b0;
    #1 chk("rst_i_busy_lo", 32'(bus.I_BUSYWAIT), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Single I read, 5-cycle memory
    mem_lat = 5;
    push(2'b01, 1'b0, 6'h05, 32'h0, 32'hDEADBEEF, 5);
    i_req(6'h05);

    // Simultaneous I read and D write: D first, then I
    mem_lat = 2;
    push(2'b10, 1'b1, 6'h0A, 32'hCAFE0001, d_rd_last, 2);
    push(2'b01, 1'b0, 6'h0B, 32'h0, mem[6'h0B], 2);
    fork
      i_req(6'h0B);
      d_req(1'b1, 1'b0, 6'h0A, 32'hCAFE0001);
    join

    // Continuous D with I pending: D,D,D,I then counter cleared -> D,D,I
    push(2'b10, 1'b0, 6'h10, 32'h0, mem[6'h10], 2);
    push(2'b10, 1'b0, 6'h11, 32'h0, mem[6'h11], 2);
    push(2'b10, 1'b0, 6'h12, 32'h0, mem[6'h12], 2);
    push(2'b01, 1'b0, 6'h20, 32'h0, mem[6'h20], 2);
    push(2'b10, 1'b0, 6'h13, 32'h0, mem[6'h13], 2);
    push(2'b10, 1'b0, 6'h14, 32'h0, mem[6'h14], 2);
    push(2'b01, 1'b0, 6'h21, 32'h0, mem[6'h21], 2);
    d_rd_last = mem[6'h14];
    fork
      begin
        i_req(6'h20);
        i_req(6'h21);
      end
      begin
        for (int unsigned k = 0; k < 5; k++) d_req(1'b0, 1'b1, 6'(6'h10 + k), 32'h0);
      end
    join

    // D read and write together: write only, D_READDATA unchanged
    push(2'b10, 1'b1, 6'h30, 32'h12345678, d_rd_last, 2);
    d_req(1'b1, 1'b1, 6'h30, 32'h12345678);
    chk("rw_d_rdata_kept", bus.D_READDATA, d_rd_last);

    // Memory already idle-low at grant: still a 2-cycle grant
    mem_lat = 0;
    push(2'b01, 1'b0, 6'h07, 32'h0, mem[6'h07], 2);
    i_req(6'h07);

    // Reset in the middle of a D write-back
    mem_lat = 10;
    push(2'b10, 1'b1, 6'h3F, 32'hA5A5A5A5, 32'h0, 10);
    @(negedge CLK);
    bus.D_WRITE = 1'b1;
    bus.D_ADDR = 6'h3F;
    bus.D_WRITEDATA = 32'hA5A5A5A5;
    got = 0;
    for (int unsigned n = 0; n < 50 && !got; n++) begin
      @(negedge CLK);
      if (bus.OWNER == 2'b10) got = 1;
    end
    chk("abort_granted", 32'(got), 32'd1);
    repeat (2) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("abort_m_write", 32'(bus.M_WRITE), 32'd0);
    chk("abort_owner", 32'(bus.OWNER), 32'd0);
    chk("abort_i_rdata", bus.I_READDATA, 32'd0);
    chk("abort_d_rdata", bus.D_READDATA, 32'd0);
    bus.D_WRITE = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    // Fresh I read after reset
    mem_lat = 3;
    push(2'b01, 1'b0, 6'h02, 32'h0, mem[6'h02], 3);
    i_req(6'h02);

    repeat (3) @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
